// File: rtl/rs232_to_axis.sv
// rs232_to_axis: RS-232 receiver feeding a 4-entry AXI-stream FIFO with RTS flow control
module rs232_to_axis #(
  parameter int CLOCK_FREQ = 133000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       rtsn,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  output logic       ferror,
  output logic       overrun
);
  localparam int BAUD_COUNT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BAUD_COUNT);
  localparam logic [CW-1:0] FULL = CW'(BAUD_COUNT - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_COUNT / 2 - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_BREAK = 3'd4;
  logic          rx_meta, rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic [7:0]    mem [4];
  logic [1:0]    wp, rp;
  logic [2:0]    count, count_nx;
  logic          expire, push, pop, push_ok;
  assign expire   = cnt == '0;
  assign push     = state == S_STOP && expire && rxs;
  assign pop      = ovalid && oready;
  assign push_ok  = push && (count != 3'd4 || pop);
  assign count_nx = count + {2'b0, push_ok} - {2'b0, pop};
  assign ovalid   = count != 3'd0;
  assign odata    = mem[rp];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  // every sample lands at the middle of a bit: half a period after the edge, then whole periods
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      ferror <= 1'b0;
    end else begin
      ferror <= state == S_STOP && expire && !rxs;
      case (state)
        S_IDLE: if (!rxs) begin
          state <= S_START;
          cnt   <= HALF;
        end
        S_START: if (expire) begin
          state <= rxs ? S_IDLE : S_DATA;
          cnt   <= FULL;
          idx   <= '0;
        end else cnt <= cnt - CW'(1);
        S_DATA: if (expire) begin
          sh    <= {rxs, sh[7:1]};
          idx   <= idx + 3'd1;
          cnt   <= FULL;
          state <= idx == 3'd7 ? S_STOP : S_DATA;
        end else cnt <= cnt - CW'(1);
        S_STOP: if (expire) state <= rxs ? S_IDLE : S_BREAK;
        else cnt <= cnt - CW'(1);
        S_BREAK: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      rtsn    <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (push_ok) mem[wp] <= sh;
      wp      <= push_ok ? wp + 2'd1 : wp;
      rp      <= pop ? rp + 2'd1 : rp;
      count   <= count_nx;
      rtsn    <= count_nx >= 3'd2;
      overrun <= push && !push_ok;
    end
endmodule

// File: tb/tb_rs232_to_axis.sv
// tb_rs232_to_axis: vector table, corner sequences and randomized frames against a queue model
module tb_rs232_to_axis;
  logic       clock = 1'b0, reset = 1'b1, rxd = 1'b1, oready = 1'b0;
  logic       rtsn, ovalid, ferror, overrun;
  logic [7:0] odata;
  int n_cmp = 0, n_bad = 0;
  int fe_cnt = 0, ov_cnt = 0, rts_cnt = 0, vh_cnt = 0;
  logic [7:0] got[$];
  logic [7:0] mq[$];
  logic       model_on = 1'b0, ef = 1'b0, eo = 1'b0;
  logic [7:0] frame_byte = '0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         nbytes;
    int         nfe;
  } vec_t;
  vec_t tv[8];

  rs232_to_axis #(.CLOCK_FREQ(16), .BAUD_RATE(1)) dut (
    .clock(clock), .reset(reset), .rxd(rxd), .rtsn(rtsn), .odata(odata),
    .ovalid(ovalid), .oready(oready), .ferror(ferror), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // one clock: drive inputs at the falling edge, then observe the outputs held since the last rising edge
  task automatic cyc(input logic r, input logic rd, input logic pe, input logic fe);
    @(negedge clock);
    rxd = r;
    oready = rd;
    if (ovalid && oready) got.push_back(odata);
    fe_cnt += int'(ferror);
    ov_cnt += int'(overrun);
    rts_cnt += int'(rtsn);
    vh_cnt += int'(ovalid);
    if (!reset && pv && !pr) chk("hold", {23'd0, ovalid, odata}, {23'd0, 1'b1, pd});
    pv = reset ? 1'b0 : ovalid;
    pr = oready;
    pd = odata;
    if (model_on) begin
      chk("m_valid", 32'(ovalid), 32'(mq.size() != 0));
      chk("m_rtsn", 32'(rtsn), 32'(mq.size() >= 2));
      if (mq.size() != 0) chk("m_data", 32'(odata), 32'(mq[0]));
      chk("m_ferror", 32'(ferror), 32'(ef));
      chk("m_overrun", 32'(overrun), 32'(eo));
      ef = fe;
      eo = 1'b0;
      if (mq.size() != 0 && rd) void'(mq.pop_front());
      if (pe) begin
        if (mq.size() < 4) mq.push_back(frame_byte);
        else eo = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) cyc(1'b1, mode == 2 ? ($urandom % 4 != 0) : mode == 1, 1'b0, 1'b0);
  endtask

  // 160-clock frame; the stop bit is sampled on the rising edge after frame clock 154
  task automatic send(input logic [7:0] d, input logic stop, input int mode, input int pulse_at, input int rst_at);
    frame_byte = d;
    for (int i = 0; i < 160; i++) begin
      logic r, rd;
      r = i < 16 ? 1'b0 : i < 144 ? d[(i - 16) / 16] : stop;
      rd = mode == 2 ? ($urandom % 4 != 0) : mode == 1;
      if (i == pulse_at) rd = 1'b1;
      cyc(r, rd, i == 154 && stop, i == 154 && !stop);
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_ovalid", 32'(ovalid), 32'd0);
        chk("rst_rtsn", 32'(rtsn), 32'd1);
        chk("rst_odata", 32'(odata), 32'd0);
      end
      if (i == rst_at + 4) reset = 1'b0;
    end
  endtask

  initial begin
    int b0, f0, o0, r0, v0;
    tv[0] = '{8'h3C, 1'b1, 1, 0};
    tv[1] = '{8'hA5, 1'b1, 1, 0};
    tv[2] = '{8'h55, 1'b0, 0, 1};
    tv[3] = '{8'h0F, 1'b1, 1, 0};
    tv[4] = '{8'h00, 1'b1, 1, 0};
    tv[5] = '{8'hFF, 1'b1, 1, 0};
    tv[6] = '{8'h80, 1'b1, 1, 0};
    tv[7] = '{8'h00, 1'b0, 0, 1};
    idle(3, 0);
    chk("reset_ovalid", 32'(ovalid), 32'd0);
    chk("reset_odata", 32'(odata), 32'd0);
    chk("reset_ferror", 32'(ferror), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_rtsn", 32'(rtsn), 32'd1);
    reset = 1'b0;
    idle(1, 1);
    chk("release_rtsn", 32'(rtsn), 32'd0);
    idle(8, 1);
    b0 = got.size(); f0 = fe_cnt;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(30, 1);
    chk("glitch_bytes", 32'(got.size() - b0), 32'd0);
    chk("glitch_ferror", 32'(fe_cnt - f0), 32'd0);
    chk("glitch_ovalid", 32'(ovalid), 32'd0);
    for (int t = 0; t < 8; t++) begin
      b0 = got.size(); f0 = fe_cnt; r0 = rts_cnt; v0 = vh_cnt;
      send(tv[t].d, tv[t].stop, 1, -1, -1);
      idle(8, 1);
      chk("vec_bytes", 32'(got.size() - b0), 32'(tv[t].nbytes));
      if (got.size() > b0) chk("vec_data", 32'(got[got.size() - 1]), 32'(tv[t].d));
      chk("vec_ferror", 32'(fe_cnt - f0), 32'(tv[t].nfe));
      chk("vec_valid_cycles", 32'(vh_cnt - v0), 32'(tv[t].nbytes));
      chk("vec_rtsn", 32'(rts_cnt - r0), 32'd0);
    end
    b0 = got.size(); o0 = ov_cnt;
    for (int k = 1; k <= 5; k++) begin
      send(8'(k), 1'b1, 0, -1, -1);
      idle(4, 0);
      if (k == 1) chk("ovf_rtsn1", 32'(rtsn), 32'd0);
      if (k == 2) chk("ovf_rtsn2", 32'(rtsn), 32'd1);
    end
    chk("ovf_overrun", 32'(ov_cnt - o0), 32'd1);
    chk("ovf_ovalid", 32'(ovalid), 32'd1);
    chk("ovf_head", 32'(odata), 32'h01);
    idle(10, 1);
    chk("ovf_drained", 32'(got.size() - b0), 32'd4);
    for (int j = 0; j < 4; j++) chk("ovf_order", 32'(got[b0 + j]), 32'(j + 1));
    chk("ovf_rtsn_end", 32'(rtsn), 32'd0);
    chk("ovf_ovalid_end", 32'(ovalid), 32'd0);
    b0 = got.size(); o0 = ov_cnt;
    for (int k = 0; k < 4; k++) begin
      send(8'h11 + 8'(k), 1'b1, 0, -1, -1);
      idle(4, 0);
    end
    chk("full_rtsn", 32'(rtsn), 32'd1);
    send(8'h15, 1'b1, 0, 154, -1);
    idle(4, 0);
    chk("full_overrun", 32'(ov_cnt - o0), 32'd0);
    chk("full_popped", 32'(got.size() - b0), 32'd1);
    chk("full_first", 32'(got[b0]), 32'h11);
    chk("full_head", 32'(odata), 32'h12);
    idle(10, 1);
    chk("full_total", 32'(got.size() - b0), 32'd5);
    for (int j = 0; j < 4; j++) chk("full_order", 32'(got[b0 + 1 + j]), 32'h12 + 32'(j));
    b0 = got.size(); f0 = fe_cnt;
    send(8'h21, 1'b1, 0, -1, -1);
    idle(4, 0);
    send(8'h22, 1'b1, 0, -1, -1);
    idle(4, 0);
    chk("mid_rtsn", 32'(rtsn), 32'd1);
    send(8'hF0, 1'b1, 0, -1, 83);
    idle(20, 1);
    chk("mid_bytes", 32'(got.size() - b0), 32'd0);
    chk("mid_ferror", 32'(fe_cnt - f0), 32'd0);
    chk("mid_ovalid", 32'(ovalid), 32'd0);
    chk("mid_rtsn_after", 32'(rtsn), 32'd0);
    mq.delete();
    ef = 1'b0;
    eo = 1'b0;
    model_on = 1'b1;
    for (int n = 0; n < 20; n++) begin
      send(8'($urandom), $urandom % 6 != 0, 2, -1, -1);
      idle(2 + int'($urandom % 7), 2);
    end
    idle(12, 1);
    model_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
